io_uart_tx: RTL

- Memory-mapped UART transmitter on the MMU IO port (io_addr/io_en/io_we/io_data_write/io_data_read) downstream of the core.
- Core stores bytes into a small TX FIFO; an 8N1 serializer shifts them out on txd at a programmable baud divisor.
- Status is readable for polling.
- Replaces the bench io memory model at IO word addresses 0x00-0x08.

---
 rtl/io_uart_tx.sv | 92 +++++++++
 1 files changed

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO, W1C overflow flag and programmable baud divisor.
module io_uart_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        txd,
    output logic        irq_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf, r_txd;
    logic [15:0]   r_div, r_div_q, r_baud;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic [5:0]    w_idx;
    logic [7:0]    w_status;
    logic          w_wr, w_push, w_pop, w_accept, w_full, w_empty, w_busy, w_bit_end, w_unused;
    assign w_idx     = io_addr[7:2];
    assign w_wr      = io_en & io_we;
    assign w_push    = w_wr & (w_idx == 6'd0);
    assign w_full    = r_count == CW'(FIFO_DEPTH);
    assign w_empty   = r_count == '0;
    assign w_busy    = r_state != IDLE;
    assign w_pop     = (r_state == IDLE) & ~w_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_bit_end = r_baud == r_div_q - 16'd1;
    assign w_status  = {4'(r_count), r_ovf, w_busy, w_empty, w_full};
    assign io_data_read = (w_idx == 6'd1) ? {24'b0, w_status} : (w_idx == 6'd2) ? {16'b0, r_div} : '0;
    assign txd       = r_txd;
    assign irq_empty = w_empty & ~w_busy;
    assign w_unused  = ^{io_addr[1:0], io_data_write[31:16]};
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= io_data_write[7:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_div    <= DIV_RESET;
            r_div_q  <= DIV_RESET;
            r_baud   <= '0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_txd    <= 1'b1;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count <= r_count + CW'(w_accept) - CW'(w_pop);
            if (w_push & ~w_accept) r_ovf <= 1'b1;
            else if (w_wr & (w_idx == 6'd1) & io_data_write[3]) r_ovf <= 1'b0;
            if (w_wr & (w_idx == 6'd2)) r_div <= (io_data_write[15:0] == '0) ? 16'd1 : io_data_write[15:0];
            r_baud <= (w_bit_end | (r_state == IDLE)) ? '0 : r_baud + 16'd1;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_shift  <= r_mem[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                    r_div_q  <= r_div;
                    r_txd    <= 1'b0;
                    r_state  <= START;
                end
                START: if (w_bit_end) begin
                    r_bit   <= '0;
                    r_txd   <= r_shift[0];
                    r_state <= DATA;
                end
                DATA: if (w_bit_end) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 3'd1;
                    r_txd   <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
                    r_state <= (r_bit == 3'd7) ? STOP : DATA;
                end
                STOP: if (w_bit_end) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
